multicycle_alu: RTL and testbench

//  Parametrised ALU for the MIPS datapath. Single-cycle logic/arith/shift/compare ops have a

---
 rtl/multicycle_alu.sv | 221 ++++++++++++++++++++++
 tb/tb_multicycle_alu.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// multicycle_alu
//   EX-stage ALU. Logic, arithmetic, shift and compare ops complete in one
//   cycle with a registered result. Unsigned multiply (shift-add) and unsigned
//   divide (restoring) iterate one bit per cycle for WIDTH cycles while Busy
//   is high. Done pulses for one cycle whenever the outputs are updated.
// Ports
//   clk, reset     rising-edge clock, synchronous active-high reset
//   Start          accept an op when Busy==0
//   ALUControl     4-bit op code, sampled with Start
//   Operand1/2     operands (A/dividend, B/divisor/shift amount)
//   ALUResult      result / MULU low word / DIVU quotient
//   ALUResultHi    MULU high word / DIVU remainder, 0 otherwise
//   Zero           ALUResult == 0
//   Overflow       signed overflow of ADD/SUB
//   DivByZero      DIVU with Operand2 == 0
//   Busy           iterative op in progress
//   Done           outputs updated this cycle
module multicycle_alu #(
  parameter int WIDTH     = 32,
  parameter int MULDIV_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] ALUResult,
  output logic [WIDTH-1:0] ALUResultHi,
  output logic             Zero,
  output logic             Overflow,
  output logic             DivByZero,
  output logic             Busy,
  output logic             Done
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_opb;   // MUL: multiplicand, DIV: divisor
  logic [WIDTH-1:0] r_acc;   // MUL: product high half, DIV: partial remainder
  logic [WIDTH-1:0] r_q;     // MUL: multiplier/product low half, DIV: dividend/quotient
  logic [WIDTH-1:0] r_res, r_hi;
  logic             r_zero, r_ovf, r_dbz, r_done;

  // A and B' agree in sign but the sum does not.
  function automatic logic f_ovf(input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b_eff,
                                 input logic [WIDTH-1:0] r);
    return (a[WIDTH-1] == b_eff[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  logic signed [WIDTH-1:0] w_op1_s, w_op2_s;
  logic [SW-1:0]           w_shamt;
  logic [WIDTH-1:0]        w_sum, w_sub, w_res;
  logic                    w_ovf;
  logic                    w_is_mul, w_is_div, w_div_iter, w_last;

  assign w_op1_s    = Operand1;
  assign w_op2_s    = Operand2;
  assign w_shamt    = Operand2[SW-1:0];
  assign w_sum      = Operand1 + Operand2;
  assign w_sub      = Operand1 - Operand2;
  assign w_is_mul   = (MULDIV_EN != 0) && (ALUControl == 4'b1100);
  assign w_is_div   = (MULDIV_EN != 0) && (ALUControl == 4'b1101);
  assign w_div_iter = w_is_div && (Operand2 != '0);
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  // Single-cycle result; undefined codes (and MUL/DIV codes here) yield 0.
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (ALUControl)
      4'b0000: w_res = Operand1 & Operand2;
      4'b0001: w_res = Operand1 | Operand2;
      4'b0010: begin
        w_res = w_sum;
        w_ovf = f_ovf(Operand1, Operand2, w_sum);
      end
      4'b0011: begin
        w_res = w_sub;
        w_ovf = f_ovf(Operand1, ~Operand2, w_sub);
      end
      4'b0100: w_res = Operand1 ^ Operand2;
      4'b0101: w_res = ~(Operand1 | Operand2);
      4'b0110: w_res = {{(WIDTH-1){1'b0}}, (w_op1_s < w_op2_s)};
      4'b0111: w_res = {{(WIDTH-1){1'b0}}, (Operand1 < Operand2)};
      4'b1000: w_res = Operand1 << w_shamt;
      4'b1001: w_res = Operand1 >> w_shamt;
      4'b1010: w_res = w_op1_s >>> w_shamt;
      default: w_res = '0;
    endcase
  end

  // Shift-add step: conditionally add multiplicand into the high half, then
  // shift the whole {carry, acc, q} right by one.
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_acc, w_mul_q;
  assign w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_opb} : '0);
  assign w_mul_acc = w_mul_sum[WIDTH:1];
  assign w_mul_q   = {w_mul_sum[0], r_q[WIDTH-1:1]};

  // Restoring divide step: shift the next dividend bit into the remainder and
  // subtract the divisor if it fits. The shifted value can be WIDTH+1 bits,
  // but when it is >= divisor the difference is below 2^WIDTH.
  logic [WIDTH:0]   w_div_shift;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_diff, w_div_acc, w_div_q;
  assign w_div_shift = {r_acc, r_q[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opb});
  assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_opb;
  assign w_div_acc   = w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
  assign w_div_q     = {r_q[WIDTH-2:0], w_div_ge};

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (Start && w_is_mul)        w_state_nxt = S_MUL;
        else if (Start && w_div_iter) w_state_nxt = S_DIV;
      end
      S_MUL, S_DIV: if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    Busy = (r_state != S_IDLE);
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_opb  <= '0;
      r_acc  <= '0;
      r_q    <= '0;
      r_res  <= '0;
      r_hi   <= '0;
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
      r_dbz  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            if (w_is_mul || w_div_iter) begin
              r_cnt <= '0;
              r_acc <= '0;
              r_opb <= w_is_mul ? Operand1 : Operand2;
              r_q   <= w_is_mul ? Operand2 : Operand1;
            end else if (w_is_div) begin
              r_res  <= '1;
              r_hi   <= Operand1;
              r_zero <= 1'b0;
              r_ovf  <= 1'b0;
              r_dbz  <= 1'b1;
              r_done <= 1'b1;
            end else begin
              r_res  <= w_res;
              r_hi   <= '0;
              r_zero <= (w_res == '0);
              r_ovf  <= w_ovf;
              r_dbz  <= 1'b0;
              r_done <= 1'b1;
            end
          end
        end
        S_MUL: begin
          r_acc <= w_mul_acc;
          r_q   <= w_mul_q;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_res  <= w_mul_q;
            r_hi   <= w_mul_acc;
            r_zero <= (w_mul_q == '0);
            r_ovf  <= 1'b0;
            r_dbz  <= 1'b0;
            r_done <= 1'b1;
          end
        end
        S_DIV: begin
          r_acc <= w_div_acc;
          r_q   <= w_div_q;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_res  <= w_div_q;
            r_hi   <= w_div_acc;
            r_zero <= (w_div_q == '0);
            r_ovf  <= 1'b0;
            r_dbz  <= 1'b0;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ALUResult   = r_res;
  assign ALUResultHi = r_hi;
  assign Zero        = r_zero;
  assign Overflow    = r_ovf;
  assign DivByZero   = r_dbz;
  assign Done        = r_done;

endmodule

// File: tb/tb_multicycle_alu.sv
module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start1, Start2;
  logic [3:0]  ALUControl;
  logic [31:0] Operand1, Operand2;

  logic [31:0] r1, h1, r2, h2;
  logic        z1, o1, d1, b1, dn1, z2, o2, d2, b2, dn2;

  multicycle_alu #(.WIDTH(32), .MULDIV_EN(1)) u_alu (
    .clk(clk), .reset(reset), .Start(Start1), .ALUControl(ALUControl),
    .Operand1(Operand1), .Operand2(Operand2), .ALUResult(r1), .ALUResultHi(h1),
    .Zero(z1), .Overflow(o1), .DivByZero(d1), .Busy(b1), .Done(dn1));

  multicycle_alu #(.WIDTH(32), .MULDIV_EN(0)) u_alu_nomd (
    .clk(clk), .reset(reset), .Start(Start2), .ALUControl(ALUControl),
    .Operand1(Operand1), .Operand2(Operand2), .ALUResult(r2), .ALUResultHi(h2),
    .Zero(z2), .Overflow(o2), .DivByZero(d2), .Busy(b2), .Done(dn2));

  always #5 clk = ~clk;

  // observed outputs of the instance under test
  logic        sel;
  logic [31:0] o_res, o_hi;
  logic        o_zero, o_ovf, o_dbz, o_busy, o_done;
  always_comb begin
    o_res  = sel ? r2  : r1;
    o_hi   = sel ? h2  : h1;
    o_zero = sel ? z2  : z1;
    o_ovf  = sel ? o2  : o1;
    o_dbz  = sel ? d2  : d1;
    o_busy = sel ? b2  : b1;
    o_done = sel ? dn2 : dn1;
  end

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic        z;
    logic        o;
    logic        d;
    int          lat;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input bit md);
    exp_t e;
    logic [63:0] p;
    e.res = '0; e.hi = '0; e.o = 1'b0; e.d = 1'b0; e.lat = 1;
    case (op)
      4'd0:  e.res = a & b;
      4'd1:  e.res = a | b;
      4'd2:  begin e.res = a + b; e.o = (a[31] == b[31]) && (e.res[31] != a[31]); end
      4'd3:  begin e.res = a - b; e.o = (a[31] != b[31]) && (e.res[31] != a[31]); end
      4'd4:  e.res = a ^ b;
      4'd5:  e.res = ~(a | b);
      4'd6:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:  e.res = (a < b) ? 32'd1 : 32'd0;
      4'd8:  e.res = a << b[4:0];
      4'd9:  e.res = a >> b[4:0];
      4'd10: e.res = $signed(a) >>> b[4:0];
      4'd12: if (md) begin
        p = {32'd0, a} * {32'd0, b};
        e.res = p[31:0]; e.hi = p[63:32]; e.lat = 33;
      end
      4'd13: if (md) begin
        if (b == 0) begin e.res = '1; e.hi = a; e.d = 1'b1; end
        else begin e.res = a / b; e.hi = a % b; e.lat = 33; end
      end
      default: e.res = '0;
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  task automatic compare(input string tag, input exp_t e);
    check({tag, ".res"},  64'(o_res),  64'(e.res));
    check({tag, ".hi"},   64'(o_hi),   64'(e.hi));
    check({tag, ".zero"}, 64'(o_zero), 64'(e.z));
    check({tag, ".ovf"},  64'(o_ovf),  64'(e.o));
    check({tag, ".dbz"},  64'(o_dbz),  64'(e.d));
  endtask

  // Issue one op, wait (bounded) for Done, then pop the scoreboard and compare.
  task automatic run_op(input string tag, input bit s, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input bit inject);
    exp_t e;
    int n, busy_n;
    q_exp.push_back(model(op, a, b, !s));
    sel = s; ALUControl = op; Operand1 = a; Operand2 = b;
    if (s) Start2 = 1'b1; else Start1 = 1'b1;
    @(posedge clk); #1;
    Start1 = 1'b0; Start2 = 1'b0;
    n = 1; busy_n = 0;
    while (!o_done && n < 40) begin
      if (o_busy) busy_n++;
      if (inject && n == 5) begin
        ALUControl = 4'b0010; Operand1 = 32'd1; Operand2 = 32'd2; Start1 = 1'b1;
      end
      if (inject && n == 6) Start1 = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    e = q_exp.pop_front();
    check({tag, ".latency"}, 64'(n), 64'(e.lat));
    check({tag, ".busy_cycles"}, 64'(busy_n), 64'(e.lat - 1));
    check({tag, ".busy_at_done"}, 64'(o_busy), 64'd0);
    compare(tag, e);
    if (inject) begin
      @(posedge clk); #1;
      check({tag, ".no_extra_done"}, 64'(o_done), 64'd0);
    end
  endtask

  initial begin
    exp_t e;
    logic [3:0] ops [13];
    logic [3:0] op;
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd14};
    sel = 1'b0; Start1 = 1'b0; Start2 = 1'b0; ALUControl = '0; Operand1 = '0; Operand2 = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("rst.res",  64'(r1),  64'd0);
    check("rst.hi",   64'(h1),  64'd0);
    check("rst.busy", 64'(b1),  64'd0);
    check("rst.done", 64'(dn1), 64'd0);
    check("rst.zero", 64'(z1),  64'd0);

    run_op("add_ovf", 0, 4'b0010, 32'h7FFF_FFFF, 32'h1, 0);
    run_op("sub_zero", 0, 4'b0011, 32'd5, 32'd5, 0);
    run_op("mulu_max", 0, 4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    run_op("divu", 0, 4'b1101, 32'd100, 32'd7, 0);
    run_op("divu_zero", 0, 4'b1101, 32'h1234, 32'd0, 0);
    run_op("sra", 0, 4'b1010, 32'h8000_0000, 32'd31, 0);
    run_op("srl", 0, 4'b1001, 32'h8000_0000, 32'd31, 0);
    run_op("slt", 0, 4'b0110, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("sltu", 0, 4'b0111, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("sll_hi_bits", 0, 4'b1000, 32'h0000_0003, 32'hFFFF_FFE4, 0);
    run_op("sub_ovf", 0, 4'b0011, 32'h8000_0000, 32'd1, 0);
    run_op("undef", 0, 4'b1111, 32'd9, 32'd9, 0);
    run_op("divu_small", 0, 4'b1101, 32'd3, 32'd10, 0);
    run_op("mulu", 0, 4'b1100, 32'd12345, 32'd6789, 0);

    // random single-cycle ops plus a few iterative ones
    for (int i = 0; i < 16; i++) begin
      op = ops[$urandom_range(0, 12)];
      run_op("rand", 0, op, $urandom, $urandom, 0);
    end
    for (int i = 0; i < 2; i++) begin
      run_op("rand_mul", 0, 4'b1100, $urandom, $urandom, 0);
      run_op("rand_div", 0, 4'b1101, $urandom, $urandom_range(1, 1000), 0);
    end

    // back-to-back single-cycle ops: Done high every cycle
    sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ALUControl = ops[i + 2]; Operand1 = $urandom; Operand2 = $urandom;
      q_exp.push_back(model(ALUControl, Operand1, Operand2, 1'b1));
      Start1 = 1'b1;
      @(posedge clk); #1;
      check("b2b.done", 64'(o_done), 64'd1);
      e = q_exp.pop_front();
      compare("b2b", e);
    end
    Start1 = 1'b0;

    // reset in the middle of a multiply
    run_op("pre_rst", 0, 4'b0100, 32'hA5A5_0000, 32'h0000_5A5A, 0);
    ALUControl = 4'b1100; Operand1 = 32'hDEAD_BEEF; Operand2 = 32'h1234_5678;
    Start1 = 1'b1;
    @(posedge clk); #1;
    Start1 = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst.busy", 64'(b1),  64'd0);
    check("midrst.done", 64'(dn1), 64'd0);
    check("midrst.res",  64'(r1),  64'd0);
    check("midrst.hi",   64'(h1),  64'd0);
    for (int i = 0; i < 35; i++) begin
      @(posedge clk); #1;
      if (dn1 || b1) check("midrst.stale", {62'd0, b1, dn1}, 64'd0);
    end
    run_op("and_after_rst", 0, 4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 0);

    // multiply/divide disabled: treated as undefined
    run_op("nomd_mulu", 1, 4'b1100, 32'd3, 32'd4, 0);
    run_op("nomd_divu", 1, 4'b1101, 32'd8, 32'd0, 0);
    run_op("nomd_add", 1, 4'b0010, 32'd3, 32'd4, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
